// File: rtl/cmd_stream_dispatcher_if.sv
// AXI4-Stream style handshake bundle shared by the dispatcher's command
// input and its three payload outputs.
interface cmd_stream_dispatcher_if #(
  parameter int WIDTH = 32
) ();
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/cmd_stream_dispatcher.sv
// Command stream dispatcher: decodes 32-bit headers from the command bus and
// routes payload to the triangle, texture (width down-converted) and fog LUT
// streams, writes the config register file and runs the framebuffer apply
// handshake. Illegal opcodes and out-of-range register indices raise a
// sticky error flag.
module cmd_stream_dispatcher #(
  parameter int CMD_STREAM_WIDTH     = 32,
  parameter int TEXTURE_STREAM_WIDTH = 16,
  parameter int CONFIG_REG_COUNT     = 8,
  parameter int CONFIG_REG_WIDTH     = 32,
  parameter int FOG_LUT_BEATS        = 33
) (
  input  logic aclk,
  input  logic resetn,
  cmd_stream_dispatcher_if.slave  s_cmd_axis,
  cmd_stream_dispatcher_if.master m_tri_axis,
  cmd_stream_dispatcher_if.master m_tex_axis,
  cmd_stream_dispatcher_if.master m_fog_axis,
  output logic [7:0] confTextureSizeX,
  output logic [7:0] confTextureSizeY,
  output logic       confTextureClampS,
  output logic       confTextureClampT,
  output logic [CONFIG_REG_COUNT*CONFIG_REG_WIDTH-1:0] confRegs,
  input  logic       rasterizerRunning,
  input  logic       pixelInPipeline,
  output logic       startRendering,
  output logic       fbApplyColor,
  output logic       fbApplyDepth,
  output logic       fbCmdCommit,
  output logic       fbCmdMemset,
  input  logic       fbApplied,
  output logic       errorFlag,
  input  logic       errorClear,
  output logic [3:0] dbgState
);
  localparam int RATIO      = CMD_STREAM_WIDTH / TEXTURE_STREAM_WIDTH;
  localparam int BYTE_SHIFT = $clog2(CMD_STREAM_WIDTH / 8);
  localparam int LANE_W     = $clog2(RATIO) + 1;

  localparam logic [3:0] OP_NOP = 4'd0, OP_TRI = 4'd1, OP_TEX = 4'd2,
                         OP_CFG = 4'd3, OP_FB  = 4'd4, OP_FOG = 4'd5;

  typedef enum logic [3:0] {
    IDLE_WAIT = 4'd0, CMD = 4'd1, TRI = 4'd2, TEX = 4'd3,
    FOG = 4'd4, CFG = 4'd5, FB_WAIT = 4'd6
  } state_t;

  state_t      state_reg;
  logic [31:0] beat_cnt_reg;
  logic [7:0]  cfg_idx_reg;
  logic        fb_phase_reg;
  logic        start_reg, err_reg;
  logic        apply_color_reg, apply_depth_reg, commit_reg, memset_reg;
  logic [7:0]  size_x_reg, size_y_reg;
  logic        clamp_s_reg, clamp_t_reg;

  logic                        tri_valid_reg, tri_last_reg;
  logic [CMD_STREAM_WIDTH-1:0] tri_data_reg;
  logic                        fog_valid_reg, fog_last_reg;
  logic [CMD_STREAM_WIDTH-1:0] fog_data_reg;
  logic [CMD_STREAM_WIDTH-1:0] tex_buf_reg;
  logic [LANE_W-1:0]           tex_lanes_reg;
  logic                        tex_final_reg;

  logic [CONFIG_REG_WIDTH-1:0] conf_regs [CONFIG_REG_COUNT];

  logic [3:0]  op;
  logic [27:0] imm;
  logic [4:0]  tex_s;
  logic [31:0] tri_beats, tex_beats;
  logic        tex_valid, tri_fire, fog_fire, tex_fire;
  logic        s_ready, s_fire, last_in, cfg_in_range, err_set;
  logic        unused_ok;

  assign op    = s_cmd_axis.tdata[31:28];
  assign imm   = s_cmd_axis.tdata[27:0];
  assign tex_s = imm[22:18];
  assign tri_beats = 32'(imm[15:0] >> BYTE_SHIFT);
  // Texture payload is at least one bus beat even for sub-beat textures.
  assign tex_beats = (tex_s <= 5'(BYTE_SHIFT)) ? 32'd1 : (32'd1 << (tex_s - 5'(BYTE_SHIFT)));

  assign tex_valid = (tex_lanes_reg != '0);
  assign tri_fire  = tri_valid_reg && m_tri_axis.tready;
  assign fog_fire  = fog_valid_reg && m_fog_axis.tready;
  assign tex_fire  = tex_valid && m_tex_axis.tready;
  assign last_in   = (beat_cnt_reg == 32'd1);
  assign cfg_in_range = ({24'd0, cfg_idx_reg} < 32'(CONFIG_REG_COUNT));

  // Input ready per state; texture path only takes a beat once the last lane is leaving.
  always_comb begin
    s_ready = 1'b0;
    case (state_reg)
      CMD, CFG: s_ready = 1'b1;
      TRI:      s_ready = !tri_valid_reg || m_tri_axis.tready;
      FOG:      s_ready = !fog_valid_reg || m_fog_axis.tready;
      TEX:      s_ready = !tex_valid || (m_tex_axis.tready && tex_lanes_reg == LANE_W'(1));
      default:  s_ready = 1'b0;
    endcase
  end

  assign s_fire  = s_cmd_axis.tvalid && s_ready;
  assign err_set = s_fire && (((state_reg == CMD) && (op > OP_FOG)) ||
                              ((state_reg == CFG) && !cfg_in_range));

  // Main control FSM: header decode, payload beat counting, framebuffer handshake.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE_WAIT;
      beat_cnt_reg <= '0;
      cfg_idx_reg <= '0;
      fb_phase_reg <= 1'b0;
      apply_color_reg <= 1'b0;
      apply_depth_reg <= 1'b0;
      commit_reg <= 1'b0;
      memset_reg <= 1'b0;
      size_x_reg <= '0;
      size_y_reg <= '0;
      clamp_s_reg <= 1'b0;
      clamp_t_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE_WAIT: begin
          if (!tri_valid_reg && !tex_valid && !fog_valid_reg && !apply_color_reg &&
              !apply_depth_reg && fbApplied && !rasterizerRunning && !pixelInPipeline &&
              !start_reg)
            state_reg <= CMD;
        end
        CMD: begin
          if (s_fire) begin
            case (op)
              OP_TRI: begin
                beat_cnt_reg <= tri_beats;
                state_reg <= (tri_beats == 32'd0) ? IDLE_WAIT : TRI;
              end
              OP_TEX: begin
                size_x_reg <= imm[7:0];
                size_y_reg <= imm[15:8];
                clamp_s_reg <= imm[16];
                clamp_t_reg <= imm[17];
                beat_cnt_reg <= tex_beats;
                state_reg <= (tex_s == 5'd0) ? IDLE_WAIT : TEX;
              end
              OP_CFG: begin
                cfg_idx_reg <= imm[7:0];
                state_reg <= CFG;
              end
              OP_FB: begin
                commit_reg <= imm[0];
                memset_reg <= imm[1];
                apply_color_reg <= imm[2];
                apply_depth_reg <= imm[3];
                fb_phase_reg <= 1'b0;
                state_reg <= (imm[2] || imm[3]) ? FB_WAIT : IDLE_WAIT;
              end
              OP_FOG: begin
                beat_cnt_reg <= 32'(FOG_LUT_BEATS);
                state_reg <= (FOG_LUT_BEATS == 0) ? IDLE_WAIT : FOG;
              end
              default: state_reg <= IDLE_WAIT;  // NOP and illegal opcodes
            endcase
          end
        end
        TRI, TEX, FOG: begin
          if (s_fire) begin
            beat_cnt_reg <= beat_cnt_reg - 32'd1;
            if (last_in)
              state_reg <= IDLE_WAIT;
          end
        end
        CFG: begin
          if (s_fire)
            state_reg <= IDLE_WAIT;
        end
        FB_WAIT: begin
          // Apply is held until the framebuffer acknowledges by dropping fbApplied,
          // then we wait for it to report completion.
          if (!fb_phase_reg) begin
            if (!fbApplied) begin
              apply_color_reg <= 1'b0;
              apply_depth_reg <= 1'b0;
              fb_phase_reg <= 1'b1;
            end
          end else if (fbApplied) begin
            state_reg <= IDLE_WAIT;
          end
        end
        default: state_reg <= IDLE_WAIT;
      endcase
    end
  end

  // Triangle output register: capture on accepted input beat, release on downstream handshake.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      tri_valid_reg <= 1'b0;
      tri_last_reg <= 1'b0;
      tri_data_reg <= '0;
    end else if (state_reg == TRI && s_fire) begin
      tri_valid_reg <= 1'b1;
      tri_last_reg <= last_in;
      tri_data_reg <= s_cmd_axis.tdata;
    end else if (tri_fire) begin
      tri_valid_reg <= 1'b0;
      tri_last_reg <= 1'b0;
    end
  end

  // Fog LUT output register, same forwarding scheme as the triangle path.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      fog_valid_reg <= 1'b0;
      fog_last_reg <= 1'b0;
      fog_data_reg <= '0;
    end else if (state_reg == FOG && s_fire) begin
      fog_valid_reg <= 1'b1;
      fog_last_reg <= last_in;
      fog_data_reg <= s_cmd_axis.tdata;
    end else if (fog_fire) begin
      fog_valid_reg <= 1'b0;
      fog_last_reg <= 1'b0;
    end
  end

  // Texture down-converter: hold one bus beat and shift out LSB lanes first.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      tex_buf_reg <= '0;
      tex_lanes_reg <= '0;
      tex_final_reg <= 1'b0;
    end else if (state_reg == TEX && s_fire) begin
      tex_buf_reg <= s_cmd_axis.tdata;
      tex_lanes_reg <= LANE_W'(RATIO);
      tex_final_reg <= last_in;
    end else if (tex_fire) begin
      tex_buf_reg <= tex_buf_reg >> TEXTURE_STREAM_WIDTH;
      tex_lanes_reg <= tex_lanes_reg - LANE_W'(1);
      if (tex_lanes_reg == LANE_W'(1))
        tex_final_reg <= 1'b0;
    end
  end

  // Config register file write from the single CFG payload beat.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CONFIG_REG_COUNT; i++)
        conf_regs[i] <= '0;
    end else if (state_reg == CFG && s_fire) begin
      for (int i = 0; i < CONFIG_REG_COUNT; i++)
        if (cfg_idx_reg == 8'(i))
          conf_regs[i] <= s_cmd_axis.tdata[CONFIG_REG_WIDTH-1:0];
    end
  end

  // Sticky error flag (set beats clear) and start-rendering level.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      err_reg <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      if (err_set)
        err_reg <= 1'b1;
      else if (errorClear)
        err_reg <= 1'b0;
      if (tri_fire && tri_last_reg)
        start_reg <= 1'b1;
      else if (rasterizerRunning)
        start_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < CONFIG_REG_COUNT; gi++) begin : g_conf
    assign confRegs[gi*CONFIG_REG_WIDTH +: CONFIG_REG_WIDTH] = conf_regs[gi];
  end

  assign s_cmd_axis.tready = s_ready;
  assign m_tri_axis.tvalid = tri_valid_reg;
  assign m_tri_axis.tlast  = tri_last_reg;
  assign m_tri_axis.tdata  = tri_data_reg;
  assign m_fog_axis.tvalid = fog_valid_reg;
  assign m_fog_axis.tlast  = fog_last_reg;
  assign m_fog_axis.tdata  = fog_data_reg;
  assign m_tex_axis.tvalid = tex_valid;
  assign m_tex_axis.tlast  = tex_final_reg && (tex_lanes_reg == LANE_W'(1));
  assign m_tex_axis.tdata  = tex_buf_reg[TEXTURE_STREAM_WIDTH-1:0];

  assign confTextureSizeX  = size_x_reg;
  assign confTextureSizeY  = size_y_reg;
  assign confTextureClampS = clamp_s_reg;
  assign confTextureClampT = clamp_t_reg;
  assign startRendering    = start_reg;
  assign fbApplyColor      = apply_color_reg;
  assign fbApplyDepth      = apply_depth_reg;
  assign fbCmdCommit       = commit_reg;
  assign fbCmdMemset       = memset_reg;
  assign errorFlag         = err_reg;
  assign dbgState          = state_reg;

  // Command tlast and header bits outside the decoded fields carry no meaning here.
  assign unused_ok = &{1'b0, s_cmd_axis.tlast, s_cmd_axis.tdata, imm};
endmodule

// File: tb/tb_cmd_stream_dispatcher.sv
// Scenario bench for cmd_stream_dispatcher with default parameters
// (32-bit command bus, 16-bit texture stream, 8 config registers, 33 fog beats).
module tb_cmd_stream_dispatcher;
  logic aclk, resetn;
  logic [7:0] confTextureSizeX, confTextureSizeY;
  logic confTextureClampS, confTextureClampT;
  logic [255:0] confRegs;
  logic rasterizerRunning, pixelInPipeline, startRendering;
  logic fbApplyColor, fbApplyDepth, fbCmdCommit, fbCmdMemset, fbApplied;
  logic errorFlag, errorClear;
  logic [3:0] dbgState;

  cmd_stream_dispatcher_if #(.WIDTH(32)) s_cmd ();
  cmd_stream_dispatcher_if #(.WIDTH(32)) tri_if ();
  cmd_stream_dispatcher_if #(.WIDTH(16)) tex_if ();
  cmd_stream_dispatcher_if #(.WIDTH(32)) fog_if ();

  cmd_stream_dispatcher dut (
    .aclk(aclk), .resetn(resetn),
    .s_cmd_axis(s_cmd), .m_tri_axis(tri_if), .m_tex_axis(tex_if), .m_fog_axis(fog_if),
    .confTextureSizeX(confTextureSizeX), .confTextureSizeY(confTextureSizeY),
    .confTextureClampS(confTextureClampS), .confTextureClampT(confTextureClampT),
    .confRegs(confRegs), .rasterizerRunning(rasterizerRunning),
    .pixelInPipeline(pixelInPipeline), .startRendering(startRendering),
    .fbApplyColor(fbApplyColor), .fbApplyDepth(fbApplyDepth),
    .fbCmdCommit(fbCmdCommit), .fbCmdMemset(fbCmdMemset), .fbApplied(fbApplied),
    .errorFlag(errorFlag), .errorClear(errorClear), .dbgState(dbgState)
  );

  int tests = 0;
  int failures = 0;
  logic [32:0] exp_tri[$], obs_tri[$];
  logic [16:0] exp_tex[$], obs_tex[$];
  logic [32:0] exp_fog[$], obs_fog[$];
  int tex_unstable = 0;
  logic tex_hold_pending = 1'b0;
  logic [15:0] tex_hold_data = '0;
  bit tex_toggle = 0;
  bit fog_rand = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Output monitor: record every handshake and any texture data change under backpressure.
  always @(negedge aclk) begin
    if (tri_if.tvalid && tri_if.tready) obs_tri.push_back({tri_if.tlast, tri_if.tdata});
    if (tex_if.tvalid && tex_if.tready) obs_tex.push_back({tex_if.tlast, tex_if.tdata});
    if (fog_if.tvalid && fog_if.tready) obs_fog.push_back({fog_if.tlast, fog_if.tdata});
    if (tex_hold_pending && tex_if.tvalid && tex_if.tdata !== tex_hold_data)
      tex_unstable <= tex_unstable + 1;
    tex_hold_pending <= tex_if.tvalid && !tex_if.tready;
    tex_hold_data <= tex_if.tdata;
  end

  // Present one command-bus word and wait (bounded) until it is accepted; leaves tvalid high.
  task automatic send_beat(input logic [31:0] d);
    bit ok;
    ok = 0;
    s_cmd.tvalid = 1'b1;
    s_cmd.tdata = d;
    for (int n = 0; n < 400; n++) begin
      @(negedge aclk);
      if (s_cmd.tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge aclk); #1;
    tests++;
    if (!ok) begin
      failures++;
      $display("FAIL send_accept: word %h got tready=%b, required 1 within 400 cycles", d, s_cmd.tready);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    tests++;
    if ({tri_if.tvalid, tex_if.tvalid, fog_if.tvalid, tri_if.tlast, tex_if.tlast, fog_if.tlast} !== 6'b0) begin
      failures++; $display("FAIL reset_valids: got %b required 000000",
        {tri_if.tvalid, tex_if.tvalid, fog_if.tvalid, tri_if.tlast, tex_if.tlast, fog_if.tlast});
    end
    tests++;
    if ({startRendering, fbApplyColor, fbApplyDepth, errorFlag} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b required 0000",
        {startRendering, fbApplyColor, fbApplyDepth, errorFlag});
    end
    tests++;
    if (dbgState !== 4'd0 || confRegs !== '0) begin
      failures++; $display("FAIL reset_state: state=%0d regs=%h required state 0 regs 0", dbgState, confRegs);
    end
    resetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    tests++;
    if (dbgState !== 4'd1) begin
      failures++; $display("FAIL idle_to_cmd: state=%0d required 1", dbgState);
    end
  endtask

  task automatic test_tri;
    logic [32:0] e, o;
    int acc;
    for (int i = 0; i < 4; i++) exp_tri.push_back({(i == 3), 32'hA5A5_0000 + 32'(i)});
    send_beat(32'h1000_0010);
    for (int i = 0; i < 4; i++) send_beat(32'hA5A5_0000 + 32'(i));
    s_cmd.tvalid = 1'b0;
    for (int n = 0; n < 200 && obs_tri.size() < exp_tri.size(); n++) begin @(posedge aclk); #2; end
    tests++;
    if (obs_tri.size() != 4) begin
      failures++; $display("FAIL tri_count: got %0d beats required 4", obs_tri.size());
    end
    while (exp_tri.size() > 0 && obs_tri.size() > 0) begin
      e = exp_tri.pop_front(); o = obs_tri.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL tri_beat: got %h required %h", o, e); end
    end
    exp_tri.delete(); obs_tri.delete();
    tests++;
    if (startRendering !== 1'b1) begin
      failures++; $display("FAIL tri_start: startRendering=%b required 1", startRendering);
    end
    // A pending header must not be taken while rendering is started.
    s_cmd.tvalid = 1'b1; s_cmd.tdata = 32'h0;
    acc = 0;
    repeat (5) begin @(negedge aclk); if (s_cmd.tready) acc++; end
    tests++;
    if (acc != 0) begin failures++; $display("FAIL tri_block: accepted %0d cycles required 0", acc); end
    @(posedge aclk); #1 rasterizerRunning = 1'b1;
    @(posedge aclk); #1 rasterizerRunning = 1'b0;
    tests++;
    if (startRendering !== 1'b0) begin
      failures++; $display("FAIL tri_start_clr: startRendering=%b required 0", startRendering);
    end
    send_beat(32'h0);
    s_cmd.tvalid = 1'b0;
  endtask

  task automatic test_tri_zero;
    send_beat(32'h1000_0003);
    s_cmd.tvalid = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    tests++;
    if (obs_tri.size() != 0 || startRendering !== 1'b0 || dbgState !== 4'd1) begin
      failures++; $display("FAIL tri_zero: beats=%0d start=%b state=%0d required 0 0 1",
        obs_tri.size(), startRendering, dbgState);
    end
    obs_tri.delete();
  endtask

  task automatic test_tex;
    logic [16:0] e, o;
    exp_tex.push_back({1'b0, 16'hAAAA}); exp_tex.push_back({1'b0, 16'hBBBB});
    exp_tex.push_back({1'b0, 16'hCCCC}); exp_tex.push_back({1'b1, 16'hDDDD});
    send_beat(32'h200C_0204);
    send_beat(32'hBBBB_AAAA);
    send_beat(32'hDDDD_CCCC);
    s_cmd.tvalid = 1'b0;
    for (int n = 0; n < 200 && obs_tex.size() < exp_tex.size(); n++) begin @(posedge aclk); #2; end
    tests++;
    if (obs_tex.size() != 4) begin
      failures++; $display("FAIL tex_count: got %0d lanes required 4", obs_tex.size());
    end
    while (exp_tex.size() > 0 && obs_tex.size() > 0) begin
      e = exp_tex.pop_front(); o = obs_tex.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL tex_lane: got %h required %h", o, e); end
    end
    exp_tex.delete(); obs_tex.delete();
    tests++;
    if (confTextureSizeX !== 8'd4 || confTextureSizeY !== 8'd2 || confTextureClampS !== 1'b0) begin
      failures++; $display("FAIL tex_conf: x=%0d y=%0d s=%b required 4 2 0",
        confTextureSizeX, confTextureSizeY, confTextureClampS);
    end
  endtask

  task automatic test_tex_backpressure;
    logic [16:0] e, o;
    logic [31:0] w;
    tex_unstable = 0;
    tex_toggle = 1;
    fork
      begin
        while (tex_toggle) begin @(posedge aclk); #1; tex_if.tready = ~tex_if.tready; end
      end
    join_none
    send_beat(32'h2011_0303);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      exp_tex.push_back({1'b0, w[15:0]});
      exp_tex.push_back({(i == 3), w[31:16]});
      send_beat(w);
    end
    s_cmd.tvalid = 1'b0;
    for (int n = 0; n < 300 && obs_tex.size() < exp_tex.size(); n++) begin @(posedge aclk); #2; end
    tex_toggle = 0;
    @(posedge aclk); #3 tex_if.tready = 1'b1;
    tests++;
    if (obs_tex.size() != 8) begin
      failures++; $display("FAIL texbp_count: got %0d lanes required 8", obs_tex.size());
    end
    while (exp_tex.size() > 0 && obs_tex.size() > 0) begin
      e = exp_tex.pop_front(); o = obs_tex.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL texbp_lane: got %h required %h", o, e); end
    end
    exp_tex.delete(); obs_tex.delete();
    tests++;
    if (tex_unstable != 0) begin
      failures++; $display("FAIL texbp_stable: %0d data changes while stalled, required 0", tex_unstable);
    end
    tests++;
    if (confTextureClampS !== 1'b1 || confTextureSizeX !== 8'd3) begin
      failures++; $display("FAIL texbp_conf: clampS=%b x=%0d required 1 3", confTextureClampS, confTextureSizeX);
    end
  endtask

  task automatic test_cfg;
    logic [255:0] model;
    model = '0;
    send_beat(32'h3000_0002); send_beat(32'h1234_5678);
    s_cmd.tvalid = 1'b0;
    model[2*32 +: 32] = 32'h1234_5678;
    tests++;
    if (confRegs[2*32 +: 32] !== 32'h1234_5678) begin
      failures++; $display("FAIL cfg_idx2: got %h required 12345678", confRegs[2*32 +: 32]);
    end
    send_beat(32'h3000_0007); send_beat(32'hCAFE_F00D);
    s_cmd.tvalid = 1'b0;
    model[7*32 +: 32] = 32'hCAFE_F00D;
    send_beat(32'h3000_0009); send_beat(32'hDEAD_BEEF);
    s_cmd.tvalid = 1'b0;
    tests++;
    if (errorFlag !== 1'b1) begin failures++; $display("FAIL cfg_err: errorFlag=%b required 1", errorFlag); end
    tests++;
    if (confRegs !== model) begin failures++; $display("FAIL cfg_regs: got %h required %h", confRegs, model); end
    errorClear = 1'b1;
    @(posedge aclk); #1 errorClear = 1'b0;
    tests++;
    if (errorFlag !== 1'b0) begin failures++; $display("FAIL cfg_clear: errorFlag=%b required 0", errorFlag); end
  endtask

  task automatic test_fb;
    int acc;
    send_beat(32'h4000_0005);
    s_cmd.tvalid = 1'b0;
    tests++;
    if ({fbApplyColor, fbApplyDepth, fbCmdCommit, fbCmdMemset} !== 4'b1010) begin
      failures++; $display("FAIL fb_latch: got %b required 1010",
        {fbApplyColor, fbApplyDepth, fbCmdCommit, fbCmdMemset});
    end
    repeat (2) @(posedge aclk);
    #1;
    tests++;
    if (fbApplyColor !== 1'b1) begin failures++; $display("FAIL fb_hold: fbApplyColor=%b required 1", fbApplyColor); end
    fbApplied = 1'b0;
    @(posedge aclk); #1;
    tests++;
    if (fbApplyColor !== 1'b0) begin failures++; $display("FAIL fb_drop: fbApplyColor=%b required 0", fbApplyColor); end
    s_cmd.tvalid = 1'b1; s_cmd.tdata = 32'h0;
    acc = 0;
    repeat (2) begin @(negedge aclk); if (s_cmd.tready) acc++; end
    tests++;
    if (acc != 0) begin failures++; $display("FAIL fb_block: accepted %0d cycles required 0", acc); end
    @(posedge aclk); #1 fbApplied = 1'b1;
    send_beat(32'h0);
    s_cmd.tvalid = 1'b0;
  endtask

  task automatic test_illegal;
    errorClear = 1'b1;
    send_beat(32'hF000_0000);
    s_cmd.tvalid = 1'b0;
    errorClear = 1'b0;
    tests++;
    if (errorFlag !== 1'b1) begin failures++; $display("FAIL illegal_err: errorFlag=%b required 1", errorFlag); end
    repeat (2) @(posedge aclk);
    #1;
    tests++;
    if (dbgState !== 4'd1) begin failures++; $display("FAIL illegal_state: state=%0d required 1", dbgState); end
  endtask

  task automatic test_reset_mid_fog;
    logic [32:0] e, o;
    logic [31:0] w;
    send_beat(32'h5000_0000);
    for (int i = 0; i < 10; i++) send_beat(32'h0F0F_0000 + 32'(i));
    #2 resetn = 1'b0;
    #1;
    tests++;
    if (fog_if.tvalid !== 1'b0 || dbgState !== 4'd0 || errorFlag !== 1'b0 || s_cmd.tready !== 1'b0) begin
      failures++; $display("FAIL midreset: valid=%b state=%0d err=%b tready=%b required 0 0 0 0",
        fog_if.tvalid, dbgState, errorFlag, s_cmd.tready);
    end
    tests++;
    if (confRegs !== '0 || confTextureSizeX !== 8'd0 || confTextureClampS !== 1'b0) begin
      failures++; $display("FAIL midreset_conf: regs=%h x=%0d s=%b required 0", confRegs, confTextureSizeX, confTextureClampS);
    end
    s_cmd.tvalid = 1'b0;
    @(posedge aclk); #1 resetn = 1'b1;
    exp_fog.delete(); obs_fog.delete();
    fog_rand = 1;
    fork
      begin
        while (fog_rand) begin @(posedge aclk); #1; fog_if.tready = 1'($urandom_range(0, 1)); end
      end
    join_none
    send_beat(32'h5000_0000);
    for (int i = 0; i < 33; i++) begin
      w = $urandom;
      exp_fog.push_back({(i == 32), w});
      send_beat(w);
    end
    s_cmd.tvalid = 1'b0;
    for (int n = 0; n < 600 && obs_fog.size() < exp_fog.size(); n++) begin @(posedge aclk); #2; end
    fog_rand = 0;
    @(posedge aclk); #3 fog_if.tready = 1'b1;
    tests++;
    if (obs_fog.size() != 33) begin
      failures++; $display("FAIL fog_count: got %0d beats required 33", obs_fog.size());
    end
    while (exp_fog.size() > 0 && obs_fog.size() > 0) begin
      e = exp_fog.pop_front(); o = obs_fog.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL fog_beat: got %h required %h", o, e); end
    end
    exp_fog.delete(); obs_fog.delete();
  endtask

  initial begin
    resetn = 1'b0;
    s_cmd.tvalid = 1'b0; s_cmd.tdata = '0; s_cmd.tlast = 1'b0;
    tri_if.tready = 1'b1; tex_if.tready = 1'b1; fog_if.tready = 1'b1;
    rasterizerRunning = 1'b0; pixelInPipeline = 1'b0;
    fbApplied = 1'b1; errorClear = 1'b0;
    test_reset;
    test_tri;
    test_tri_zero;
    test_tex;
    test_tex_backpressure;
    test_cfg;
    test_fb;
    test_illegal;
    test_reset_mid_fog;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
